mips_control_unit: RTL and testbench

- Control sequencer for the single-cycle MIPS datapath.
- Decodes the current instruction word into the datapath mux selects, register/memory write enables and ALU control.
- Sequences an external iterative multiply/divide unit, which owns the hi/lo registers, through a start/done handshake. It stalls the PC on hi/lo hazards.
- Halts on illegal opcodes and on multiply/divide timeouts.

---
 rtl/mips_control_unit_pkg.sv | 68 ++++++
 rtl/mips_control_unit_if.sv | 30 +++
 rtl/mips_control_unit_main_decoder.sv | 72 +++++++
 rtl/mips_control_unit.sv | 102 ++++++++++
 tb/tb_mips_control_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_control_unit_pkg.sv
// Shared encodings for the MIPS control sequencer: opcodes, functs, mux selects,
// ALU codes, error codes, FSM states and the decoded control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic       WA3_RD    = 1'b0;
    localparam logic       WA3_RT    = 1'b1;
    localparam logic [1:0] WD_ALU    = 2'd0;
    localparam logic [1:0] WD_MEM    = 2'd1;
    localparam logic [1:0] WD_HI     = 2'd2;
    localparam logic [1:0] WD_LO     = 2'd3;
    localparam logic       SRCB_REG  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MD_BUSY,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       wa3_sel;
        logic [1:0] wd_sel;
        logic       srcb_sel;
        logic [2:0] alu_ctrl;
        logic       reg_we;
        logic       mem_we;
        logic       is_beq;
        logic       is_bne;
        logic       is_jump;
        logic [1:0] md_op;
    } ctrl_t;

endpackage

// File: rtl/mips_control_unit_if.sv
// Datapath-facing bundle of the control unit: instruction/flags in, controls out.
interface mips_control_unit_if;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        md_done;
    logic        write_addr3_sel;
    logic [1:0]  reg_write_data_sel;
    logic        alu_src_b_sel;
    logic [1:0]  PC_sel;
    logic [2:0]  alu_ctrl;
    logic        reg_write_en;
    logic        mem_write_en;
    logic        pc_en;
    logic        md_start;
    logic [1:0]  md_op;
    logic        halted;
    logic [1:0]  err_code;

    modport master (
        input  instruction, alu_zero, md_done,
        output write_addr3_sel, reg_write_data_sel, alu_src_b_sel, PC_sel, alu_ctrl,
               reg_write_en, mem_write_en, pc_en, md_start, md_op, halted, err_code
    );

    modport slave (
        output instruction, alu_zero, md_done,
        input  write_addr3_sel, reg_write_data_sel, alu_src_b_sel, PC_sel, alu_ctrl,
               reg_write_en, mem_write_en, pc_en, md_start, md_op, halted, err_code
    );
endinterface

// File: rtl/mips_control_unit_main_decoder.sv
// Stateless instruction decode: control bundle plus mul/div, hi/lo-read and illegal flags.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_is_md,
    output logic       o_is_hilo_read,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl         = '0;
        o_is_md        = 1'b0;
        o_is_hilo_read = 1'b0;
        o_illegal      = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.wa3_sel  = WA3_RD;
                o_ctrl.srcb_sel = SRCB_REG;
                case (i_funct)
                    FN_ADD: begin o_ctrl.reg_we = 1'b1; o_ctrl.alu_ctrl = ALU_ADD; end
                    FN_SUB: begin o_ctrl.reg_we = 1'b1; o_ctrl.alu_ctrl = ALU_SUB; end
                    FN_AND: begin o_ctrl.reg_we = 1'b1; o_ctrl.alu_ctrl = ALU_AND; end
                    FN_OR:  begin o_ctrl.reg_we = 1'b1; o_ctrl.alu_ctrl = ALU_OR;  end
                    FN_SLT: begin o_ctrl.reg_we = 1'b1; o_ctrl.alu_ctrl = ALU_SLT; end
                    FN_MFHI: begin
                        o_ctrl.reg_we  = 1'b1;
                        o_ctrl.wd_sel  = WD_HI;
                        o_is_hilo_read = 1'b1;
                    end
                    FN_MFLO: begin
                        o_ctrl.reg_we  = 1'b1;
                        o_ctrl.wd_sel  = WD_LO;
                        o_is_hilo_read = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        o_ctrl.md_op = i_funct[1:0];
                        o_is_md      = 1'b1;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                o_ctrl.wa3_sel  = WA3_RT;
                o_ctrl.wd_sel   = WD_MEM;
                o_ctrl.srcb_sel = SRCB_IMM;
                o_ctrl.alu_ctrl = ALU_ADD;
                o_ctrl.reg_we   = 1'b1;
            end
            OP_SW: begin
                o_ctrl.srcb_sel = SRCB_IMM;
                o_ctrl.alu_ctrl = ALU_ADD;
                o_ctrl.mem_we   = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                o_ctrl.wa3_sel  = WA3_RT;
                o_ctrl.srcb_sel = SRCB_IMM;
                o_ctrl.reg_we   = 1'b1;
                o_ctrl.alu_ctrl = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            OP_BEQ: begin o_ctrl.alu_ctrl = ALU_SUB; o_ctrl.is_beq = 1'b1; end
            OP_BNE: begin o_ctrl.alu_ctrl = ALU_SUB; o_ctrl.is_bne = 1'b1; end
            OP_J:   o_ctrl.is_jump = 1'b1;
            default: o_illegal = 1'b1;
        endcase
        // Illegal words must not leak any partial decode onto the datapath.
        if (o_illegal) o_ctrl = '0;
    end

endmodule

// File: rtl/mips_control_unit.sv
// Control sequencer: Mealy decode gated by a BOOT/RUN/MD_BUSY/HALT FSM that
// issues mul/div ops, stalls hi/lo users while busy, and halts on faults.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic                clk,
    input  logic                reset,
    mips_control_unit_if.master bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_err;

    ctrl_t w_ctrl;
    logic  w_is_md, w_is_hilo, w_illegal;
    logic  w_active, w_legal, w_stall, w_take;
    logic  w_unused_bits;

    assign w_unused_bits = ^bus.instruction[25:6];

    mips_main_decoder u_dec (
        .i_opcode      (bus.instruction[31:26]),
        .i_funct       (bus.instruction[5:0]),
        .o_ctrl        (w_ctrl),
        .o_is_md       (w_is_md),
        .o_is_hilo_read(w_is_hilo),
        .o_illegal     (w_illegal)
    );

    assign w_active = (r_state == ST_RUN) || (r_state == ST_MD_BUSY);
    assign w_legal  = w_active && !w_illegal;
    // Anything touching hi/lo waits until the unit reports done.
    assign w_stall  = (r_state == ST_MD_BUSY) && (w_is_md || w_is_hilo);
    assign w_take   = (w_ctrl.is_beq && bus.alu_zero) || (w_ctrl.is_bne && !bus.alu_zero);

    always_comb begin
        bus.write_addr3_sel    = 1'b0;
        bus.reg_write_data_sel = 2'd0;
        bus.alu_src_b_sel      = 1'b0;
        bus.PC_sel             = PC_PLUS4;
        bus.alu_ctrl           = 3'b000;
        bus.reg_write_en       = 1'b0;
        bus.mem_write_en       = 1'b0;
        bus.pc_en              = 1'b0;
        bus.md_start           = 1'b0;
        bus.md_op              = 2'b00;
        if (w_legal) begin
            bus.write_addr3_sel    = w_ctrl.wa3_sel;
            bus.reg_write_data_sel = w_ctrl.wd_sel;
            bus.alu_src_b_sel      = w_ctrl.srcb_sel;
            bus.alu_ctrl           = w_ctrl.alu_ctrl;
            bus.PC_sel             = w_ctrl.is_jump ? PC_JUMP : (w_take ? PC_BRANCH : PC_PLUS4);
            bus.reg_write_en       = w_ctrl.reg_we && !w_stall;
            bus.mem_write_en       = w_ctrl.mem_we && !w_stall;
            bus.pc_en              = !w_stall;
            bus.md_start           = w_is_md && !w_stall;
            bus.md_op              = (w_is_md && !w_stall) ? w_ctrl.md_op : 2'b00;
        end
    end

    assign bus.halted   = (r_state == ST_HALT);
    assign bus.err_code = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_cnt   <= '0;
            r_err   <= ERR_NONE;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_illegal) begin
                        r_state <= ST_HALT;
                        r_err   <= ERR_ILLEGAL;
                    end else if (w_is_md) begin
                        r_state <= ST_MD_BUSY;
                        r_cnt   <= '0;
                    end
                end
                ST_MD_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_illegal) begin
                        r_state <= ST_HALT;
                        r_err   <= ERR_ILLEGAL;
                    end else if (bus.md_done) begin
                        r_state <= ST_RUN;
                    end else if (r_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        r_state <= ST_HALT;
                        r_err   <= ERR_TIMEOUT;
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Randomised and directed checks of the control unit against a spec-level model.
module tb_mips_control_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_control_unit_if bus ();

    mips_control_unit #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0 boot, 1 run, 2 waiting on mul/div, 3 halted.
    int         m_mode = 0;
    int         m_busy = 0;
    logic [1:0] m_err  = 2'b00;

    function automatic logic [31:0] rt(input logic [5:0] fn);
        return {6'h00, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)), 5'd0, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op);
        return {op, 5'($urandom_range(31)), 5'($urandom_range(31)), 16'($urandom)};
    endfunction

    // Classify by spec table: 0 illegal, 1 plain, 2 hi/lo read, 3 mul/div issue.
    function automatic int kind(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) return 1;
            if (fn inside {6'h10, 6'h12}) return 2;
            if (fn >= 6'h18 && fn <= 6'h1B) return 3;
            return 0;
        end
        if (op inside {6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02}) return 1;
        return 0;
    endfunction

    // {wa3, wd[2], srcb, pc[2], alu[3], rwe, mwe, pce, mds, mdop[2], halted, err[2]}
    function automatic logic [17:0] model_out(input logic [31:0] ins, input logic z);
        logic wa, sb, rwe, mwe, pce, mds;
        logic [1:0] wd, pc, mdop;
        logic [2:0] alu;
        logic [5:0] op, fn;
        int k;
        {wa, sb, rwe, mwe, pce, mds} = '0;
        wd = 0; pc = 0; mdop = 0; alu = 0;
        op = ins[31:26];
        fn = ins[5:0];
        k  = kind(ins);
        if ((m_mode == 1 || m_mode == 2) && k != 0) begin
            pce = 1'b1;
            if (op == 6'h00) begin
                if (k != 3) rwe = 1'b1;
                if (fn == 6'h20) alu = 3'b010;
                if (fn == 6'h22) alu = 3'b110;
                if (fn == 6'h24) alu = 3'b000;
                if (fn == 6'h25) alu = 3'b001;
                if (fn == 6'h2A) alu = 3'b111;
                if (fn == 6'h10) wd = 2;
                if (fn == 6'h12) wd = 3;
                if (k == 3) begin mds = 1'b1; mdop = fn[1:0]; end
            end else if (op == 6'h23) begin
                wa = 1; wd = 1; sb = 1; alu = 3'b010; rwe = 1;
            end else if (op == 6'h2B) begin
                sb = 1; alu = 3'b010; mwe = 1;
            end else if (op == 6'h08 || op == 6'h0A) begin
                wa = 1; sb = 1; rwe = 1; alu = (op == 6'h0A) ? 3'b111 : 3'b010;
            end else if (op == 6'h04) begin
                alu = 3'b110; pc = z ? 2'd1 : 2'd0;
            end else if (op == 6'h05) begin
                alu = 3'b110; pc = z ? 2'd0 : 2'd1;
            end else if (op == 6'h02) begin
                pc = 2'd2;
            end
            if (m_mode == 2 && k >= 2) begin
                pce = 0; rwe = 0; mwe = 0; mds = 0; mdop = 0;
            end
        end
        return {wa, wd, sb, pc, alu, rwe, mwe, pce, mds, mdop, m_mode == 3, m_err};
    endfunction

    function automatic logic [17:0] sample();
        return {bus.write_addr3_sel, bus.reg_write_data_sel, bus.alu_src_b_sel, bus.PC_sel,
                bus.alu_ctrl, bus.reg_write_en, bus.mem_write_en, bus.pc_en, bus.md_start,
                bus.md_op, bus.halted, bus.err_code};
    endfunction

    function automatic void model_step(input logic [31:0] ins, input logic d);
        int k;
        k = kind(ins);
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (k == 0) begin m_mode = 3; m_err = 2'b01; end
                else if (k == 3) begin m_mode = 2; m_busy = 0; end
            end
            2: begin
                m_busy++;
                if (k == 0) begin m_mode = 3; m_err = 2'b01; end
                else if (d) m_mode = 1;
                else if (m_busy >= 64) begin m_mode = 3; m_err = 2'b10; end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic z, input logic d);
        bus.instruction = ins;
        bus.alu_zero    = z;
        bus.md_done     = d;
        #2;
    endtask

    task automatic advance(input logic [31:0] ins, input logic d);
        model_step(ins, d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        m_mode = 0; m_busy = 0; m_err = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] got, exp;
        apply_reset();
        drive(32'h012A4020, 1'b0, 1'b0);
        got = sample(); exp = model_out(32'h012A4020, 1'b0);
        total++;
        if (got !== exp || got !== 18'h0) begin
            bad++; $display("FAIL boot_cycle got=%h want=%h", got, exp);
        end
        advance(32'h012A4020, 1'b0);
        drive(32'h012A4020, 1'b0, 1'b0);
        total++;
        if (bus.reg_write_en !== 1'b1 || bus.alu_ctrl !== 3'b010 || bus.write_addr3_sel !== 1'b0 || bus.pc_en !== 1'b1) begin
            bad++; $display("FAIL run_add got=%h want rwe=1 alu=010 wa3=0 pce=1", sample());
        end
        advance(32'h012A4020, 1'b0);
    endtask

    task automatic test_alu_mem();
        logic [31:0] seq [8];
        logic [17:0] got, exp;
        seq = '{32'h8C880004, 32'hAC880008, rt(6'h22), rt(6'h24), rt(6'h25), rt(6'h2A), it(6'h08), it(6'h0A)};
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], 1'($urandom), 1'b0);
            got = sample(); exp = model_out(seq[i], bus.alu_zero);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL alu_mem[%0d] ins=%h got=%h want=%h", i, seq[i], got, exp);
            end
            advance(seq[i], 1'b0);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [6];
        logic        zs  [6];
        logic [1:0]  pcw [6];
        ins = '{it(6'h04), it(6'h05), it(6'h04), it(6'h05), 32'h08000010, it(6'h04)};
        zs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pcw = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], zs[i], 1'b0);
            total++;
            if (bus.PC_sel !== pcw[i] || sample() !== model_out(ins[i], zs[i])) begin
                bad++; $display("FAIL branch[%0d] pc_sel=%0d want=%0d vec=%h", i, bus.PC_sel, pcw[i], sample());
            end
            advance(ins[i], 1'b0);
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] ins;
        logic [17:0] got, exp;
        logic        done;
        int          stalls;
        stalls = 0;
        // Cycle 0 issues mult, cycle 1 add, cycles 2.. mflo; done at cycle 5.
        for (int c = 0; c < 8; c++) begin
            ins  = (c == 0) ? rt(6'h18) : (c == 1) ? rt(6'h20) : rt(6'h12);
            done = (c == 5);
            drive(ins, 1'b0, done);
            got = sample(); exp = model_out(ins, 1'b0);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL muldiv[%0d] got=%h want=%h", c, got, exp);
            end
            if (c >= 2 && bus.pc_en === 1'b0) stalls++;
            if (c == 6) begin
                total++;
                if (bus.pc_en !== 1'b1 || bus.reg_write_data_sel !== 2'd3 || stalls != 4) begin
                    bad++; $display("FAIL mflo_release pce=%b wd=%0d stalls=%0d want 1/3/4", bus.pc_en, bus.reg_write_data_sel, stalls);
                end
            end
            advance(ins, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic        prev;
        prev = 1'b0;
        // Second mult lands while busy: must stall, then issue only after done.
        for (int c = 0; c < 6; c++) begin
            ins = (c < 5) ? rt(6'h19 + 6'(c % 3)) : rt(6'h20);
            drive(ins, 1'b0, c == 2);
            total++;
            if (sample() !== model_out(ins, 1'b0) || (prev && bus.md_start)) begin
                bad++; $display("FAIL b2b[%0d] got=%h want=%h prev_start=%b", c, sample(), model_out(ins, 1'b0), prev);
            end
            prev = bus.md_start;
            advance(ins, c == 2);
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        logic [31:0] ins;
        int          busy_cycles;
        busy_cycles = 0;
        drive(32'h0, 1'b0, 1'b0);
        advance(32'h0, 1'b0);
        ins = rt(6'h1A);
        for (int c = 0; c < 80 && !bus.halted; c++) begin
            drive(ins, 1'b0, 1'b0);
            if (bus.halted) break;
            total++;
            if (sample() !== model_out(ins, 1'b0)) begin
                bad++; $display("FAIL timeout_cycle[%0d] got=%h want=%h", c, sample(), model_out(ins, 1'b0));
            end
            if (c > 0) busy_cycles++;
            advance(ins, 1'b0);
            ins = rt(6'h20);
        end
        total++;
        if (bus.halted !== 1'b1 || bus.err_code !== 2'b10 || busy_cycles != 64 || bus.pc_en !== 1'b0) begin
            bad++; $display("FAIL timeout halted=%b err=%b busy=%0d want 1/10/64", bus.halted, bus.err_code, busy_cycles);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins;
        apply_reset();
        drive(32'h0, 1'b0, 1'b0);
        advance(32'h0, 1'b0);
        ins = {6'h3F, 26'h1234567};
        drive(ins, 1'b0, 1'b0);
        total++;
        if (bus.pc_en !== 1'b0 || sample() !== 18'h0) begin
            bad++; $display("FAIL illegal_now got=%h want=0", sample());
        end
        advance(ins, 1'b0);
        drive(rt(6'h20), 1'b0, 1'b0);
        total++;
        if (bus.halted !== 1'b1 || bus.err_code !== 2'b01 || bus.reg_write_en !== 1'b0) begin
            bad++; $display("FAIL illegal_halt halted=%b err=%b rwe=%b want 1/01/0", bus.halted, bus.err_code, bus.reg_write_en);
        end
        advance(rt(6'h20), 1'b0);
        // Bad funct while busy, then reset out of HALT and out of MD_BUSY.
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            ins = (c == 0) ? 32'h0 : (c == 1) ? rt(6'h1B) : (c == 2) ? rt(6'h20) : rt(6'h3F);
            drive(ins, 1'b0, 1'b0);
            total++;
            if (sample() !== model_out(ins, 1'b0)) begin
                bad++; $display("FAIL busy_illegal[%0d] got=%h want=%h", c, sample(), model_out(ins, 1'b0));
            end
            advance(ins, 1'b0);
        end
        drive(rt(6'h20), 1'b0, 1'b0);
        total++;
        if (bus.err_code !== 2'b01 || bus.halted !== 1'b1) begin
            bad++; $display("FAIL busy_illegal_err err=%b halted=%b want 01/1", bus.err_code, bus.halted);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.err_code !== 2'b00 || bus.halted !== 1'b0) begin
            bad++; $display("FAIL reset_from_halt err=%b halted=%b want 00/0", bus.err_code, bus.halted);
        end
        apply_reset();
        drive(32'h0, 1'b0, 1'b0);
        advance(32'h0, 1'b0);
        drive(rt(6'h18), 1'b0, 1'b0);
        advance(rt(6'h18), 1'b0);
        apply_reset();
        drive(rt(6'h12), 1'b0, 1'b0);
        total++;
        if (sample() !== 18'h0) begin
            bad++; $display("FAIL reset_from_busy got=%h want=0", sample());
        end
        advance(rt(6'h12), 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [17:0] got, exp;
        logic        z, d, prev;
        logic [5:0]  fns [11];
        logic [5:0]  ops [7];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
        ops = '{6'h23, 6'h2B, 6'h08, 6'h0A, 6'h04, 6'h05, 6'h02};
        prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (m_mode == 3 && $urandom_range(3) == 0) begin
                apply_reset();
                prev = 1'b0;
            end
            case ($urandom_range(39))
                0:               ins = $urandom;
                1,2,3,4,5,6,7,8,
                9,10,11,12,13,
                14,15,16,17:     ins = rt(fns[$urandom_range(10)]);
                default:         ins = it(ops[$urandom_range(6)]);
            endcase
            z = 1'($urandom);
            d = ($urandom_range(5) == 0);
            drive(ins, z, d);
            got = sample(); exp = model_out(ins, z);
            total++;
            if (got !== exp || (prev && bus.md_start)) begin
                bad++; $display("FAIL random[%0d] ins=%h z=%b d=%b got=%h want=%h", c, ins, z, d, got, exp);
            end
            prev = bus.md_start;
            advance(ins, d);
        end
    endtask

    initial begin
        bus.instruction = 32'h0;
        bus.alu_zero    = 1'b0;
        bus.md_done     = 1'b0;
        #1;
        test_reset();
        test_alu_mem();
        test_branch();
        test_muldiv();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
